// File: rtl/tron_pkg.sv
// Shared opcode, condition and flag definitions for the tron core.
// Combinational constants only; no latency and no flow control.
package tron_pkg;

  typedef enum logic [1:0] {FETCH, DECODE, EXECUTE} state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_PASSB, ALU_LSH
  } alu_fn_t;

  // Primary opcodes; immediate opcodes share their encoding with the ext codes below.
  localparam logic [3:0] OP_RR    = 4'b0000;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_SPEC  = 4'b0100;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_LUI   = 4'b1111;

  localparam logic [3:0] FN_ADD = 4'b0101;
  localparam logic [3:0] FN_SUB = 4'b1001;
  localparam logic [3:0] FN_AND = 4'b0001;
  localparam logic [3:0] FN_OR  = 4'b0010;
  localparam logic [3:0] FN_XOR = 4'b0011;
  localparam logic [3:0] FN_MOV = 4'b1101;
  localparam logic [3:0] FN_CMP = 4'b1011;

  localparam logic [3:0] EXT_LSH   = 4'b0100;
  localparam logic [3:0] EXT_LSHI0 = 4'b0000;
  localparam logic [3:0] EXT_LSHI1 = 4'b0001;
  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3;
  localparam logic [3:0] COND_HI = 4'd4,  COND_LS = 4'd5,  COND_GT = 4'd6,  COND_LE = 4'd7;
  localparam logic [3:0] COND_FS = 4'd8,  COND_FC = 4'd9,  COND_LO = 4'd10, COND_HS = 4'd11;
  localparam logic [3:0] COND_LT = 4'd12, COND_GE = 4'd13, COND_UC = 4'd14, COND_NV = 4'd15;

  localparam int FLAG_C = 0;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_L = 4;
  localparam int FLAG_N = 7;

  function automatic logic cond_true(input logic [3:0] cond,
                                     input logic c, f, z, l, n);
    logic t;
    t = 1'b0;
    case (cond)
      COND_EQ: t = z;
      COND_NE: t = !z;
      COND_CS: t = c;
      COND_CC: t = !c;
      COND_HI: t = !l && !z;
      COND_LS: t = l || z;
      COND_GT: t = n;
      COND_LE: t = !n;
      COND_FS: t = f;
      COND_FC: t = !f;
      COND_LO: t = l;
      COND_HS: t = !l;
      COND_LT: t = !n && !z;
      COND_GE: t = n || z;
      COND_UC: t = 1'b1;
      COND_NV: t = 1'b0;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tron_alu.sv
// Combinational 16-bit ALU with carry/overflow and compare flags.
// Zero latency; no flow control.
module tron_alu
  import tron_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  alu_fn_t     fn,
  output logic [15:0] y,
  output logic        c,
  output logic        f,
  output logic        z,
  output logic        l,
  output logic        n
);

  logic [16:0] sum;
  logic [16:0] diff;
  logic [15:0] mag;

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    mag  = b[15] ? (16'd0 - b) : b;
    z    = (a == b);
    l    = (a < b);
    n    = ($signed(a) > $signed(b));
    y    = sum[15:0];
    c    = 1'b0;
    f    = 1'b0;
    case (fn)
      ALU_ADD: begin
        y = sum[15:0];
        c = sum[16];
        f = (a[15] == b[15]) && (sum[15] != a[15]);
      end
      ALU_SUB: begin
        y = diff[15:0];
        c = diff[16];
        f = (a[15] != b[15]) && (diff[15] != a[15]);
      end
      ALU_AND:   y = a & b;
      ALU_OR:    y = a | b;
      ALU_XOR:   y = a ^ b;
      ALU_PASSB: y = b;
      // b is a signed shift count: negative means logical right shift
      ALU_LSH: begin
        if (mag >= 16'd16) y = 16'h0000;
        else if (b[15])    y = a >> mag[3:0];
        else               y = a << mag[3:0];
      end
      default: y = sum[15:0];
    endcase
  end

endmodule

// File: rtl/tron.sv
// Multi-cycle 16-bit CR16-style core: FETCH/DECODE/EXECUTE, 3 cycles per instruction.
// Instructions are consumed unconditionally in FETCH; there is no backpressure.
module tron
  import tron_pkg::*;
#(
  parameter int DMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instruction,
  output logic [15:0] addressOut,
  output logic [15:0] busOutput
);

  localparam int AW = $clog2(DMEM_DEPTH);

  state_t      state;
  logic [15:0] pc, ir, a_q, b_q, flags, bus_q;
  logic [15:0] regs [16];
  logic [15:0] dmem [DMEM_DEPTH];

  logic [3:0]  op, rd, ext;
  logic [7:0]  imm8;
  alu_fn_t     fn;
  logic [15:0] src, alu_y, wb, next_pc, flags_nx;
  logic        alu_c, alu_f, alu_z, alu_l, alu_n;
  logic        wr, mw, bus_en, fl_ar, fl_cmp, sel_mem, sel_link, sel_rd;
  logic        reg_write, mem_write;

  assign op   = ir[15:12];
  assign rd   = ir[11:8];
  assign ext  = ir[7:4];
  assign imm8 = ir[7:0];

  tron_alu u_alu (
    .a (a_q), .b (src), .fn (fn),
    .y (alu_y), .c (alu_c), .f (alu_f), .z (alu_z), .l (alu_l), .n (alu_n)
  );

  always_comb begin
    fn = ALU_ADD; src = b_q; wr = 1'b0; mw = 1'b0; bus_en = 1'b0;
    fl_ar = 1'b0; fl_cmp = 1'b0; sel_mem = 1'b0; sel_link = 1'b0; sel_rd = 1'b0;
    next_pc = pc + 16'd1;
    case (op)
      OP_RR: begin
        wr = 1'b1;
        case (ext)
          FN_ADD:  begin fn = ALU_ADD; fl_ar = 1'b1; end
          FN_SUB:  begin fn = ALU_SUB; fl_ar = 1'b1; end
          FN_AND:  fn = ALU_AND;
          FN_OR:   fn = ALU_OR;
          FN_XOR:  fn = ALU_XOR;
          FN_MOV:  fn = ALU_PASSB;
          FN_CMP:  begin fn = ALU_SUB; fl_cmp = 1'b1; wr = 1'b0; end
          default: wr = 1'b0;
        endcase
      end
      FN_ADD: begin fn = ALU_ADD; src = {{8{imm8[7]}}, imm8}; wr = 1'b1; fl_ar = 1'b1; end
      FN_SUB: begin fn = ALU_SUB; src = {{8{imm8[7]}}, imm8}; wr = 1'b1; fl_ar = 1'b1; end
      FN_CMP: begin fn = ALU_SUB; src = {{8{imm8[7]}}, imm8}; fl_cmp = 1'b1; end
      FN_AND: begin fn = ALU_AND;   src = {8'h00, imm8}; wr = 1'b1; end
      FN_OR:  begin fn = ALU_OR;    src = {8'h00, imm8}; wr = 1'b1; end
      FN_XOR: begin fn = ALU_XOR;   src = {8'h00, imm8}; wr = 1'b1; end
      FN_MOV: begin fn = ALU_PASSB; src = {8'h00, imm8}; wr = 1'b1; end
      OP_LUI: begin fn = ALU_PASSB; src = {imm8, 8'h00}; wr = 1'b1; end
      OP_SHIFT: begin
        fn = ALU_LSH;
        if (ext == EXT_LSH) wr = 1'b1;
        else if (ext == EXT_LSHI0 || ext == EXT_LSHI1) begin
          src = {12'h000, ir[3:0]};
          wr  = 1'b1;
        end
      end
      OP_SPEC: begin
        case (ext)
          EXT_LOAD:  begin wr = 1'b1; sel_mem = 1'b1; end
          EXT_STOR:  begin mw = 1'b1; sel_rd = 1'b1; end
          EXT_JAL:   begin wr = 1'b1; sel_link = 1'b1; next_pc = b_q; end
          EXT_JCOND: if (cond_true(rd, flags[FLAG_C], flags[FLAG_F], flags[FLAG_Z],
                                   flags[FLAG_L], flags[FLAG_N])) next_pc = b_q;
          default: ;
        endcase
      end
      OP_BCOND:
        if (cond_true(rd, flags[FLAG_C], flags[FLAG_F], flags[FLAG_Z],
                      flags[FLAG_L], flags[FLAG_N]))
          next_pc = pc + {{8{imm8[7]}}, imm8};
      default: ;
    endcase
    bus_en = wr || mw;

    if (sel_mem)       wb = dmem[b_q[AW-1:0]];
    else if (sel_link) wb = pc + 16'd1;
    else if (sel_rd)   wb = a_q;
    else               wb = alu_y;

    flags_nx = flags;
    if (fl_ar) begin
      flags_nx[FLAG_C] = alu_c;
      flags_nx[FLAG_F] = alu_f;
    end
    if (fl_cmp) begin
      flags_nx         = 16'h0000;
      flags_nx[FLAG_C] = alu_c;
      flags_nx[FLAG_F] = alu_f;
      flags_nx[FLAG_Z] = alu_z;
      flags_nx[FLAG_L] = alu_l;
      flags_nx[FLAG_N] = alu_n;
    end
  end

  assign reg_write  = (state == EXECUTE) && wr;
  assign mem_write  = (state == EXECUTE) && mw;
  assign addressOut = pc;
  assign busOutput  = (state == EXECUTE && bus_en) ? wb : bus_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      pc    <= 16'h0000;
      ir    <= 16'h0000;
      a_q   <= 16'h0000;
      b_q   <= 16'h0000;
      flags <= 16'h0000;
      bus_q <= 16'h0000;
      for (int i = 0; i < 16; i++) regs[i] <= 16'(i);
    end else begin
      case (state)
        FETCH: begin
          ir    <= instruction;
          state <= DECODE;
        end
        DECODE: begin
          a_q   <= regs[rd];
          b_q   <= regs[ir[3:0]];
          state <= EXECUTE;
        end
        EXECUTE: begin
          if (reg_write) regs[rd] <= wb;
          if (bus_en)    bus_q <= wb;
          flags <= flags_nx;
          pc    <= next_pc;
          state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Memory contents survive reset; only the store itself is cancelled.
  always_ff @(posedge clk) begin
    if (!reset && mem_write) dmem[b_q[AW-1:0]] <= a_q;
  end

endmodule

// File: tb/tb_tron.sv
// Directed-vector bench for tron: runs a fixed program and checks the result bus,
// strobes, PC and flags against hand-computed values.
module tb_tron;

  logic        clk;
  logic        reset;
  logic [15:0] instruction;
  logic [15:0] addressOut;
  logic [15:0] busOutput;

  int total = 0;
  int bad   = 0;

  logic [15:0] bus_x;
  logic        rw_x, mw_x;

  tron dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .addressOut  (addressOut),
    .busOutput   (busOutput)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge with the core in FETCH; returns in the next FETCH.
  task automatic run(input logic [15:0] ins);
    instruction = ins;
    @(posedge clk);
    @(posedge clk);
    #1;
    bus_x = busOutput;
    rw_x  = dut.reg_write;
    mw_x  = dut.mem_write;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    instruction = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc",    addressOut, 16'h0000);
    check("rst_bus",   busOutput,  16'h0000);
    check("rst_flags", dut.flags,  16'h0000);
    check("rst_r7",    dut.regs[7], 16'h0007);
    reset = 1'b0;

    run(16'h0152);
    check("add_bus", bus_x, 16'h0003);
    check("add_rw",  16'(rw_x), 16'h0001);
    check("add_pc",  addressOut, 16'h0001);
    check("add_flags", dut.flags, 16'h0000);

    run(16'hD101);
    run(16'h5193);
    check("addi_bus", bus_x, 16'hFF94);
    check("addi_flags", dut.flags, 16'h0000);
    run(16'hD101);
    run(16'h9101);
    check("subi_bus", bus_x, 16'h0000);
    run(16'hD101);
    run(16'h210E);
    check("ori_bus", bus_x, 16'h000F);
    run(16'hD100);
    run(16'h9101);
    check("subi_borrow_bus", bus_x, 16'hFFFF);
    check("subi_borrow_flags", dut.flags, 16'h0001);

    run(16'hD101);
    run(16'h01B1);
    check("cmp_rw", 16'(rw_x), 16'h0000);
    check("cmp_flags", dut.flags, 16'h0008);
    run(16'hB102);
    check("cmpi_flags", dut.flags, 16'h0011);
    run(16'h0152);
    check("add_keep_bus", bus_x, 16'h0003);
    check("add_keep_flags", dut.flags, 16'h0010);

    run(16'hD101);
    run(16'h8143);
    check("lsh_bus", bus_x, 16'h0008);
    run(16'hD600);
    run(16'h9602);
    check("subi_neg_flags", dut.flags, 16'h0011);
    run(16'h8146);
    check("lsh_right_bus", bus_x, 16'h0002);
    run(16'hD710);
    run(16'h8147);
    check("lsh_16_bus", bus_x, 16'h0000);
    run(16'hD101);
    run(16'h8101);
    check("lshi_bus", bus_x, 16'h0002);
    run(16'hF101);
    check("lui_bus", bus_x, 16'h0100);

    run(16'h4541);
    check("stor_mw",  16'(mw_x), 16'h0001);
    check("stor_rw",  16'(rw_x), 16'h0000);
    check("stor_bus", bus_x, 16'h0005);
    run(16'h4101);
    check("load_rw",  16'(rw_x), 16'h0001);
    check("load_bus", bus_x, 16'h0005);
    check("load_pc",  addressOut, 16'h0019);

    run(16'h4182);
    check("jal_bus", bus_x, 16'h001A);
    check("jal_pc",  addressOut, 16'h0002);
    run(16'h01D1);
    check("jal_link_r1", bus_x, 16'h001A);
    run(16'hCE03);
    check("buc_pc", addressOut, 16'h0006);
    run(16'hCEFF);
    check("buc_back_pc", addressOut, 16'h0005);
    run(16'h01B2);
    check("cmp_gt_flags", dut.flags, 16'h0080);
    run(16'h40C1);
    check("jeq_not_pc", addressOut, 16'h0007);
    run(16'h41C1);
    check("jne_pc", addressOut, 16'h001A);
    run(16'hC005);
    check("beq_not_pc", addressOut, 16'h001B);
    run(16'hCF05);
    check("bnv_pc", addressOut, 16'h001C);
    check("bus_hold", busOutput, 16'h001A);

    run(16'hD100);
    instruction = 16'h4341;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("abort_mw", 16'(dut.mem_write), 16'h0001);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_pc",    addressOut, 16'h0000);
    check("abort_bus",   busOutput,  16'h0000);
    check("abort_flags", dut.flags,  16'h0000);
    run(16'h4100);
    check("abort_nowrite", bus_x, 16'h0005);
    check("abort_next_pc", addressOut, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
